// File: rtl/gate_exerciser.sv
// ---------------------------------------------------------------------------
// gate_exerciser
//   Self-checking stimulus generator and checker for the two-input basic-gate
//   block. It steps {a_o,b_o} through 00,01,10,11 and holds each vector for
//   SETTLE_CYCLES cycles. It then samples the seven gate outputs for one CHECK
//   cycle and compares them with the truth table. At the end of the sweep it
//   reports pass/fail and a mismatch count.
//
// Parameters
//   SETTLE_CYCLES : cycles each vector is held before sampling (1..255)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, accepted only in IDLE
//   gates_i    in   [6:0] observed gates {AND,OR,NOT a,NAND,NOR,XOR,XNOR}
//   a_o, b_o   out  stimulus to the gate block
//   busy       out  high from start acceptance until DONE is left
//   done       out  one-cycle pulse at the end of a run
//   pass       out  run result, held until the next accepted start
//   err_cnt    out  [2:0] number of mismatching vectors (0..4)
//   first_fail out  [9:0] {valid, a, b, observed[6:0]} of first mismatch
//
// Configuration macro
//   GATE_EXERCISER_FIRST_FAIL_EN : when defined, first_fail captures the
//   first mismatching vector. Otherwise the port is tied to zero.
// ---------------------------------------------------------------------------
module gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] gates_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [9:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Truth table of the gate block for a given {a,b} vector.
  function automatic logic [6:0] expected_gates(input logic [1:0] vec);
    logic [6:0] res;
    case (vec)
      2'b00:   res = 7'h1D;
      2'b01:   res = 7'h3A;
      2'b10:   res = 7'h2A;
      2'b11:   res = 7'h61;
      default: res = 7'h00;
    endcase
    return res;
  endfunction

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err;

  logic       w_start_acc;
  logic       w_mismatch;
  logic [2:0] w_err_next;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_mismatch  = (r_state == ST_CHECK) &&
                       (gates_i != expected_gates({r_a, r_b}));

  // Error count after the current CHECK, saturating at 4 vectors.
  always_comb begin
    w_err_next = r_err;
    if (w_mismatch && (r_err != 3'd4)) begin
      w_err_next = r_err + 3'd1;
    end else begin
      w_err_next = r_err;
    end
  end

  // Sequencer: state, settle counter, stimulus and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_err   <= 3'd0;
            r_pass  <= 1'b0;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == SETTLE_LAST) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_err <= w_err_next;
          if ({r_a, r_b} == 2'b11) begin
            // pass is resolved here so it is valid in the DONE cycle itself.
            r_pass  <= (w_err_next == 3'd0);
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            {r_a, r_b} <= {r_a, r_b} + 2'b01;
            r_cnt      <= 8'd0;
            r_state    <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GATE_EXERCISER_FIRST_FAIL_EN
  logic [9:0] r_first_fail;

  // Capture the first mismatching vector of a run; bit 9 marks it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_fail <= 10'h000;
    end else if (w_start_acc) begin
      r_first_fail <= 10'h000;
    end else if (w_mismatch && !r_first_fail[9]) begin
      r_first_fail <= {1'b1, r_a, r_b, gates_i};
    end else begin
      r_first_fail <= r_first_fail;
    end
  end

  assign first_fail = r_first_fail;
`else
  logic w_unused_start_acc;
  assign w_unused_start_acc = w_start_acc;
  assign first_fail         = 10'h000;
`endif

  assign a_o     = r_a;
  assign b_o     = r_b;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_gate_exerciser.sv
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [6:0] gates0, gates1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [9:0] ff0, ff1;

  // Fault injection on the modelled gate block: observed = (good & and_mask) ^ xor_mask[vec]
  logic [6:0] and_mask;
  logic [6:0] xor_mask [4];

  int n_vec = 0;
  int n_bad = 0;

  // Reference gate behaviour from boolean definitions.
  function automatic logic [6:0] good(input logic a, input logic b);
    return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  function automatic logic [6:0] observed(input int n);
    logic [1:0] v;
    v = 2'(n);
    return (good(v[1], v[0]) & and_mask) ^ xor_mask[n];
  endfunction

  assign gates0 = (good(a0, b0) & and_mask) ^ xor_mask[{a0, b0}];
  assign gates1 = (good(a1, b1) & and_mask) ^ xor_mask[{a1, b1}];

  gate_exerciser #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .gates_i(gates0),
    .a_o(a0), .b_o(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_fail(ff0)
  );

  gate_exerciser #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gates_i(gates1),
    .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail(ff1)
  );

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outputs c cycles after the start edge, for settle time s.
  task automatic check_cycle(input string tag, input int s, input int c,
                             input logic busy, input logic done,
                             input logic a, input logic b, input logic pass,
                             input logic [2:0] err, input logic [9:0] ff);
    int t, vec, e_err;
    logic [9:0] e_ff;
    logic [6:0] obs;
    t     = 4 * (s + 1) + 1;
    vec   = (c < t) ? (c - 1) / (s + 1) : 3;
    e_err = 0;
    e_ff  = 10'h000;
    for (int n = 0; n < 4; n++) begin
      obs = observed(n);
      if (obs != good(n[1], n[0]) && ((n + 1) * (s + 1) + 1 <= c)) begin
        e_err++;
        if (!e_ff[9]) e_ff = {1'b1, 2'(n), obs};
      end
    end
`ifndef GATE_EXERCISER_FIRST_FAIL_EN
    e_ff = 10'h000;
`endif
    cmp($sformatf("%s c%0d busy", tag, c), int'(busy), (c <= t) ? 1 : 0);
    cmp($sformatf("%s c%0d done", tag, c), int'(done), (c == t) ? 1 : 0);
    cmp($sformatf("%s c%0d ab", tag, c), int'({a, b}), vec);
    cmp($sformatf("%s c%0d err_cnt", tag, c), int'(err), e_err);
    cmp($sformatf("%s c%0d pass", tag, c), int'(pass), (c >= t && e_err == 0) ? 1 : 0);
    cmp($sformatf("%s c%0d first_fail", tag, c), int'(ff), int'(e_ff));
  endtask

  // One sweep on both DUTs; start is also pulsed in each DUT's DONE cycle.
  task automatic run(input string tag, input bit hold);
    @(negedge clk);
    start0 = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    if (!hold) start0 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check_cycle({tag, "/s2"}, 2, c, busy0, done0, a0, b0, pass0, err0, ff0);
      check_cycle({tag, "/s1"}, 1, c, busy1, done1, a1, b1, pass1, err1, ff1);
      if (c == 13) start0 = 1'b1;
      if (c == 14) start0 = 1'b0;
      if (c == 9)  start1 = 1'b1;
      if (c == 10) start1 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, " ab0"}, int'({a0, b0}), 0);
    cmp({tag, " busy0"}, int'(busy0), 0);
    cmp({tag, " done0"}, int'(done0), 0);
    cmp({tag, " pass0"}, int'(pass0), 0);
    cmp({tag, " err0"}, int'(err0), 0);
    cmp({tag, " ff0"}, int'(ff0), 0);
    cmp({tag, " busy1"}, int'(busy1), 0);
    cmp({tag, " ab1"}, int'({a1, b1}), 0);
  endtask

  typedef struct {
    string      name;
    logic [6:0] and_m;
    int         e_err;
    logic       e_pass;
    logic [9:0] e_ff;
  } vec_t;

  vec_t tbl [3];

  initial begin
    tbl[0] = '{name: "clean",     and_m: 7'h7F, e_err: 0, e_pass: 1'b1, e_ff: 10'h000};
    tbl[1] = '{name: "xor_stuck", and_m: 7'h7D, e_err: 2, e_pass: 1'b0, e_ff: 10'b1_01_0111000};
    tbl[2] = '{name: "all_zero",  and_m: 7'h00, e_err: 4, e_pass: 1'b0, e_ff: 10'b1_00_0000000};

    rst_n    = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    and_mask = 7'h7F;
    for (int i = 0; i < 4; i++) xor_mask[i] = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: fault pattern, then final result of the default-settle DUT.
    for (int i = 0; i < 3; i++) begin
      and_mask = tbl[i].and_m;
      run(tbl[i].name, 1'b0);
      cmp({tbl[i].name, " final err_cnt"}, int'(err0), tbl[i].e_err);
      cmp({tbl[i].name, " final pass"}, int'(pass0), int'(tbl[i].e_pass));
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
      cmp({tbl[i].name, " final first_fail"}, int'(ff0), int'(tbl[i].e_ff));
`else
      cmp({tbl[i].name, " final first_fail"}, int'(ff0), 0);
`endif
    end

    // start held high for the whole run: still exactly one sweep.
    and_mask = 7'h7F;
    run("hold", 1'b1);

    // Reset during the SETTLE of vector 10 on the default DUT.
    @(negedge clk);
    start0 = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int c = 1; c < 7; c++) begin
      @(posedge clk); #1;
    end
    cmp("midrst ab before reset", int'({a0, b0}), 2);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      cmp($sformatf("post-reset c%0d done0", c), int'(done0), 0);
      cmp($sformatf("post-reset c%0d busy0", c), int'(busy0), 0);
    end
    run("after_reset", 1'b0);
    cmp("after_reset pass", int'(pass0), 1);

    // Random fault patterns checked against the model.
    for (int r = 0; r < 8; r++) begin
      and_mask = 7'h7F;
      for (int i = 0; i < 4; i++)
        xor_mask[i] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'h00;
      run($sformatf("rand%0d", r), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Self-checking stimulus generator and checker for the two-input basic-gate block. It drives the gate block's `a`/`b` inputs through all four input combinations and waits a programmable settle time per vector. It then samples the seven gate outputs, compares them against the truth table and reports pass/fail with an error count. It sits beside the gate block on the board-level test top, with `start` driven by a debounced button and `pass`/`err_cnt` shown on LEDs.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  run request; accepted only in IDLE.
- `gates_i`  in  7  observed gate outputs: bit6 AND, bit5 OR, bit4 NOT(a), bit3 NAND, bit2 NOR, bit1 XOR, bit0 XNOR.
- `a_o`, `b_o`  out  1 each  stimulus to the gate block.
- `busy`  out  1  high from start acceptance until DONE is left.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  run result; held until the next start is accepted.
- `err_cnt`  out  3  number of mismatching vectors (0..4).
- `first_fail`  out  10  {valid, a, b, observed[6:0]} of the first mismatching vector.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE with `start`=1 (sampled at the edge):
  - `{a_o,b_o}` <= 2'b00, `err_cnt` <= 0, `pass` <= 0, `first_fail` <= 0, settle counter <= 0, `busy` <= 1.
  - Next state is SETTLE.
- SETTLE: counter increments each cycle. After `SETTLE_CYCLES` cycles in SETTLE, go to CHECK.
- CHECK (one cycle): compare `gates_i` with the expected value for the current `{a_o,b_o}`:
  - 00 -> 7'h1D
  - 01 -> 7'h3A
  - 10 -> 7'h2A
  - 11 -> 7'h61
- On mismatch, `err_cnt` increments by 1, once per vector regardless of how many bits differ.
- After CHECK:
  - If `{a_o,b_o}`=11, go to DONE.
  - Otherwise `{a_o,b_o}` increments, the counter clears, and the next state is SETTLE.
- DONE (one cycle): `done`=1; `pass` <= (`err_cnt`==0, including the final CHECK result); next state is IDLE; `busy` drops on leaving DONE.
- `start` outside IDLE, including in the DONE cycle, is ignored with no effect.
- `a_o`/`b_o` hold their last vector (11) in IDLE after a run.
- `err_cnt` cannot exceed 4 and never wraps.

## Timing
- Reset values: state IDLE; `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail`=0.
- All outputs are registered. `busy` and `done` are decoded from registered state.
- Per-vector time is `SETTLE_CYCLES`+1 cycles.
- Define cycle 0 as the edge where `start` is sampled in IDLE:
  - `busy` rises after edge 0.
  - CHECK of vector n occupies cycle (n+1)·(`SETTLE_CYCLES`+1).
  - `done` is high during cycle 4·(`SETTLE_CYCLES`+1)+1; for the default this is cycle 13.
  - `pass`/`err_cnt` are final from that cycle onward.
- Reset asserted mid-run: all registers return to reset values immediately, with no `done` pulse. A new run needs a fresh `start` after `rst_n` is released.
- `gates_i` is sampled only in CHECK. It is treated as synchronous and not double-registered.

## Configuration
- `GATE_EXERCISER_FIRST_FAIL_EN` defined:
  - In the first CHECK that mismatches since start, `first_fail` <= {1, `a_o`, `b_o`, `gates_i`}.
  - Later mismatches leave it unchanged.
  - It clears on start acceptance and on reset.
- Not defined: `first_fail` is tied to 10'h000, no capture register is built, and the port remains present.

## Test plan
- Model-correct gate block, `SETTLE_CYCLES`=2, `start` pulse -> `a_o`/`b_o` step 00,01,10,11 every 3 cycles; `done` high in cycle 13; `pass`=1; `err_cnt`=0; `first_fail`=0.
- XOR output stuck at 0 (`gates_i[1]` forced 0) -> `err_cnt`=2, `pass`=0; with the macro, `first_fail`=10'b1_01_0111000 (vector 01, observed 7'h38).
- All `gates_i` forced 7'h00 -> `err_cnt`=4, `pass`=0; with the macro, `first_fail`={1,00,7'h00}.
- `start` held high throughout the run and pulsed in the DONE cycle -> exactly one run; `done` pulses once; `busy` returns to 0 in the cycle after DONE.
- `rst_n` pulled low during the SETTLE of vector 10 -> all outputs at reset values immediately, no `done`. A following `start` runs a full clean sweep with `pass`=1.
- `SETTLE_CYCLES`=1 -> vectors change every 2 cycles; `done` in cycle 9.
